// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache miss controller.
package cache_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;

  localparam logic [1:0] BS_WORD = 2'd0;
  localparam logic [1:0] BS_BYTE = 2'd1;
  localparam logic [1:0] BS_HALF = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP,
    ST_WB,
    ST_FILL,
    ST_INSTALL
  } state_t;

  // The reserved size code 3 behaves like a full word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      BS_BYTE: is_misaligned = 1'b0;
      BS_HALF: is_misaligned = lsb[0];
      default: is_misaligned = (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// Refill assembly register: one word written per accepted memory beat, word 0 in the LSBs.
module cache_line_buf
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [IDX_W-1:0]             i_idx,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W*LINE_WORDS-1:0] o_line
);

  logic [LINE_WORDS-1:0][DATA_W-1:0] r_words;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_words <= '0;
    end else if (i_we) begin
      r_words[i_idx] <= i_wdata;
    end
  end

  assign o_line = r_words;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Request sequencer for one data cache: lookup, dirty-victim writeback, line refill,
// install and replay, with saturating miss/writeback statistics.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = cache_pkg::LINE_WORDS,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [1:0]                   req_byte_size,
  output logic                         resp_valid,
  output logic                         resp_err,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic [ADDR_W-1:0]            cache_addr,
  output logic [DATA_W-1:0]            cache_wdata,
  output logic [1:0]                   cache_byte_size,
  output logic                         cache_rd,
  output logic                         cache_wr,
  output logic                         cache_fill,
  output logic [DATA_W*LINE_WORDS-1:0] cache_fill_data,
  input  logic                         cache_hit,
  input  logic                         cache_dirty,
  input  logic [DATA_W-1:0]            cache_rdata,
  input  logic [ADDR_W-1:0]            cache_victim_addr,
  input  logic [DATA_W*LINE_WORDS-1:0] cache_victim_data,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [CNT_W-1:0]             miss_cnt,
  output logic [CNT_W-1:0]             wb_cnt
);

  localparam int unsigned IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_t                            r_state;
  logic                              r_write;
  logic [IDX_W-1:0]                  r_idx;
  logic [ADDR_W-1:0]                 r_victim_addr;
  logic [LINE_WORDS-1:0][DATA_W-1:0] r_victim_data;

  logic [IDX_W-1:0]  w_idx_nxt;
  logic [ADDR_W-1:0] w_word_off;
  logic [ADDR_W-1:0] w_line_base;
  logic [DATA_W-1:0] w_load_data;
  logic              w_buf_we;

  // cache_addr doubles as the latched request address.
  assign w_idx_nxt   = r_idx + IDX_W'(1);
  assign w_word_off  = ADDR_W'({w_idx_nxt, 2'b00});
  assign w_line_base = {cache_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign w_buf_we    = (r_state == ST_FILL) && mem_ready;

  always_comb begin
    w_load_data = cache_rdata;
    case (cache_byte_size)
      BS_BYTE: w_load_data = DATA_W'(cache_rdata[7:0]);
      BS_HALF: w_load_data = DATA_W'(cache_rdata[15:0]);
      default: w_load_data = cache_rdata;
    endcase
  end

  cache_line_buf #(
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX_W)
  ) u_line_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_buf_we),
    .i_idx  (r_idx),
    .i_wdata(mem_rdata),
    .o_line (cache_fill_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_write         <= 1'b0;
      r_idx           <= '0;
      r_victim_addr   <= '0;
      r_victim_data   <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rdata      <= '0;
      cache_addr      <= '0;
      cache_wdata     <= '0;
      cache_byte_size <= '0;
      cache_rd        <= 1'b0;
      cache_wr        <= 1'b0;
      cache_fill      <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      miss_cnt        <= '0;
      wb_cnt          <= '0;
    end else begin
      resp_valid <= 1'b0;
      cache_rd   <= 1'b0;
      cache_wr   <= 1'b0;
      cache_fill <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            cache_addr      <= req_addr;
            cache_wdata     <= req_wdata;
            cache_byte_size <= req_byte_size;
            r_write         <= req_write;
            req_ready       <= 1'b0;
            if (is_misaligned(req_byte_size, req_addr[1:0])) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              r_state    <= ST_RESP;
            end else begin
              resp_err <= 1'b0;
              cache_rd <= ~req_write;
              cache_wr <= req_write;
              r_state  <= ST_LOOKUP;
            end
          end
        end
        ST_LOOKUP: begin
          if (cache_hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= r_write ? '0 : w_load_data;
            r_state    <= ST_RESP;
          end else begin
            r_idx   <= '0;
            mem_req <= 1'b1;
            if (cache_dirty) begin
              r_victim_addr <= cache_victim_addr;
              r_victim_data <= cache_victim_data;
              mem_we        <= 1'b1;
              mem_addr      <= cache_victim_addr;
              mem_wdata     <= cache_victim_data[DATA_W-1:0];
              r_state       <= ST_WB;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= w_line_base;
              r_state  <= ST_FILL;
            end
          end
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_WB: begin
          if (mem_ready) begin
            if (r_idx == LAST_IDX) begin
              r_idx     <= '0;
              mem_we    <= 1'b0;
              mem_addr  <= w_line_base;
              mem_wdata <= '0;
              if (wb_cnt != '1) wb_cnt <= wb_cnt + CNT_W'(1);
              r_state   <= ST_FILL;
            end else begin
              r_idx     <= w_idx_nxt;
              mem_addr  <= r_victim_addr + w_word_off;
              mem_wdata <= r_victim_data[w_idx_nxt];
            end
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            if (r_idx == LAST_IDX) begin
              r_idx      <= '0;
              mem_req    <= 1'b0;
              cache_fill <= 1'b1;
              r_state    <= ST_INSTALL;
            end else begin
              r_idx    <= w_idx_nxt;
              mem_addr <= w_line_base + w_word_off;
            end
          end
        end
        ST_INSTALL: begin
          // Replay the original access; it now hits the installed line.
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
          cache_rd <= ~r_write;
          cache_wr <= r_write;
          r_state  <= ST_LOOKUP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
